// File: rtl/dcm_reset_seq_if.sv
// -----------------------------------------------------------------------------
// dcm_reset_seq_if
//   Bundle of signals between the DCM reset sequencer, the DCM and the system.
//   clk25 and rst are not part of the bundle; they are plain ports on the
//   sequencer.
//
//   dcm_locked    DCM LOCKED flag, asynchronous to clk25
//   dcm_rst       DCM RST input, active-high
//   sys_rst       system reset, active-high, clk25 domain
//   seq_state     debug: 0=DCM_RST 1=WAIT_LOCK 2=STABLE 3=RUN
//   timeout_err   sticky: at least one lock timeout since rst
//   relock_count  saturating count of lock losses seen in RUN
//
//   master : the sequencer (drives resets and status, reads lock)
//   slave  : the DCM/system side (drives lock, reads resets and status)
// -----------------------------------------------------------------------------
interface dcm_reset_seq_if;
  logic       dcm_locked;
  logic       dcm_rst;
  logic       sys_rst;
  logic [1:0] seq_state;
  logic       timeout_err;
  logic [7:0] relock_count;

  modport master (
    input  dcm_locked,
    output dcm_rst,
    output sys_rst,
    output seq_state,
    output timeout_err,
    output relock_count
  );

  modport slave (
    output dcm_locked,
    input  dcm_rst,
    input  sys_rst,
    input  seq_state,
    input  timeout_err,
    input  relock_count
  );
endinterface

// File: rtl/dcm_reset_seq.sv
// -----------------------------------------------------------------------------
// dcm_reset_seq
//   Reset sequencer placed directly downstream of the clock DCM. It pulses the
//   DCM reset, waits for LOCKED, requires LOCKED to be stable for a hold time
//   and only then releases the system reset. A lock timeout or any sampled
//   loss of lock restarts the whole sequence with a fresh DCM reset pulse.
//   It runs from the 25 MHz reference so it keeps working when the DCM output
//   clock disappears.
//
//   Parameters
//     RST_CYCLES    cycles dcm_rst is held high per pulse
//     LOCK_TIMEOUT  cycles to wait for lock after a pulse before retrying
//     HOLD_CYCLES   consecutive locked cycles required before sys_rst drops
//     SYNC_STAGES   flops in the dcm_locked synchroniser (>= 2)
//     All counts must be in 1..65535; one 16-bit counter serves every state.
//
//   Ports
//     clk25  in  25 MHz reference clock, the only clock
//     rst    in  synchronous active-high reset
//     bus    master side of dcm_reset_seq_if (lock in, resets/status out)
// -----------------------------------------------------------------------------
module dcm_reset_seq #(
  parameter int unsigned RST_CYCLES   = 4,
  parameter int unsigned LOCK_TIMEOUT = 4096,
  parameter int unsigned HOLD_CYCLES  = 256,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic               clk25,
  input  logic               rst,
  dcm_reset_seq_if.master    bus
);

  typedef enum logic [1:0] {
    S_DCM_RST   = 2'd0,
    S_WAIT_LOCK = 2'd1,
    S_STABLE    = 2'd2,
    S_RUN       = 2'd3
  } state_t;

  // Terminal counts: each state leaves on the edge where cnt hits N-1, so the
  // state lasts exactly N cycles.
  localparam logic [15:0] RST_LAST  = 16'(RST_CYCLES - 1);
  localparam logic [15:0] TOUT_LAST = 16'(LOCK_TIMEOUT - 1);
  localparam logic [15:0] HOLD_LAST = 16'(HOLD_CYCLES - 1);

  state_t                   state, state_nxt;
  logic [15:0]              cnt, cnt_nxt;
  logic                     terr, terr_nxt;
  logic [7:0]               relock, relock_nxt;
  logic [SYNC_STAGES-1:0]   lock_sync_p;
  logic                     lock_s;
  logic                     dcm_rst_q;
  logic                     sys_rst_q;

  // Relock counter saturates rather than wrapping so a flapping DCM never
  // reads back as "few relocks".
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // ---- stage: dcm_locked synchroniser (async -> clk25) ----
  always_ff @(posedge clk25) begin
    if (rst) begin
      lock_sync_p <= '0;
    end else begin
      lock_sync_p <= {lock_sync_p[SYNC_STAGES-2:0], bus.dcm_locked};
    end
  end

  assign lock_s = lock_sync_p[SYNC_STAGES-1];

  // ---- stage: sequencing FSM, next-state logic ----
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    terr_nxt   = terr;
    relock_nxt = relock;
    case (state)
      S_DCM_RST: begin
        // Lock is deliberately ignored here: whatever LOCKED says while the
        // DCM is held in reset is stale.
        if (cnt == RST_LAST) begin
          state_nxt = S_WAIT_LOCK;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 16'd1;
        end
      end
      S_WAIT_LOCK: begin
        // Lock is tested before the timeout so a lock arriving on the very
        // last cycle is accepted without flagging an error.
        if (lock_s) begin
          state_nxt = S_STABLE;
          cnt_nxt   = '0;
        end else if (cnt == TOUT_LAST) begin
          state_nxt = S_DCM_RST;
          cnt_nxt   = '0;
          terr_nxt  = 1'b1;
        end else begin
          cnt_nxt = cnt + 16'd1;
        end
      end
      S_STABLE: begin
        // Any dropout during the hold window means the DCM is not trusted:
        // go back for a full reset pulse, not just another wait.
        if (!lock_s) begin
          state_nxt = S_DCM_RST;
          cnt_nxt   = '0;
        end else if (cnt == HOLD_LAST) begin
          state_nxt = S_RUN;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 16'd1;
        end
      end
      S_RUN: begin
        if (!lock_s) begin
          state_nxt  = S_DCM_RST;
          cnt_nxt    = '0;
          relock_nxt = sat_inc8(relock);
        end
      end
      default: begin
        state_nxt = S_DCM_RST;
        cnt_nxt   = '0;
      end
    endcase
  end

  // ---- stage: state and output registers ----
  // The reset outputs are decoded from the next state so that they are
  // registered (glitch-free into the DCM) yet change on the same edge as
  // seq_state.
  always_ff @(posedge clk25) begin
    if (rst) begin
      state     <= S_DCM_RST;
      cnt       <= '0;
      terr      <= 1'b0;
      relock    <= '0;
      dcm_rst_q <= 1'b1;
      sys_rst_q <= 1'b1;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      terr      <= terr_nxt;
      relock    <= relock_nxt;
      dcm_rst_q <= (state_nxt == S_DCM_RST);
      sys_rst_q <= (state_nxt != S_RUN);
    end
  end

  assign bus.dcm_rst      = dcm_rst_q;
  assign bus.sys_rst      = sys_rst_q;
  assign bus.seq_state    = state;
  assign bus.timeout_err  = terr;
  assign bus.relock_count = relock;

endmodule
